// File: rtl/fetch_ctrl_pkg.sv
// Shared types and helpers for the fetch-stage next-PC sequencer.
// Redirect sources are encoded so that a larger value means a higher priority.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    TRAP = 2'd2,
    WFI  = 2'd3
  } fc_state_t;

  typedef enum logic [2:0] {
    SRC_SEQ     = 3'd0,
    SRC_WFI     = 3'd1,
    SRC_PRED    = 3'd2,
    SRC_RET     = 3'd3,
    SRC_MISPRED = 3'd4,
    SRC_MRET    = 3'd5,
    SRC_TRAP    = 3'd6
  } redir_src_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  // Redirects resolved in EX or later must also kill the instruction in ID.
  function automatic logic kills_id(input redir_src_t src);
    return (src == SRC_TRAP) || (src == SRC_MRET) || (src == SRC_MISPRED);
  endfunction

  function automatic logic kills_if(input redir_src_t src);
    return src >= SRC_PRED;
  endfunction

endpackage

// File: rtl/redirect_prio_enc.sv
// Fixed-priority selector of the winning redirect source and its aligned target.
module redirect_prio_enc
  import fetch_ctrl_pkg::*;
(
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  input  logic        mret,
  input  logic [31:0] mepc,
  input  logic        mispred,
  input  logic [31:0] mispred_tgt,
  input  logic        ret,
  input  logic [31:0] ra,
  input  logic        pred,
  input  logic [31:0] pred_tgt,
  input  logic        wfi,
  input  logic [31:0] cur_pc,
  output redir_src_t  src,
  output logic [31:0] tgt
);

  logic [31:0] seq_pc;

  assign seq_pc = cur_pc + PC_STEP;

  always_comb begin
    src = SRC_SEQ;
    tgt = align_pc(seq_pc);
    if (trap_req) begin
      src = SRC_TRAP;
      tgt = align_pc(trap_vec);
    end else if (mret) begin
      src = SRC_MRET;
      tgt = align_pc(mepc);
    end else if (mispred) begin
      src = SRC_MISPRED;
      tgt = align_pc(mispred_tgt);
    end else if (ret) begin
      src = SRC_RET;
      tgt = align_pc(ra);
    end else if (pred) begin
      src = SRC_PRED;
      tgt = align_pc(pred_tgt);
    end else if (wfi) begin
      src = SRC_WFI;
      tgt = align_pc(cur_pc);
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Next-PC sequencer: arbitrates redirects, holds them across stalls,
// sequences trap entry latency and WFI sleep.
module fetch_redirect_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned TRAP_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic [31:0] cur_pc_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_vec_i,
  input  logic        mret_i,
  input  logic [31:0] mepc_i,
  input  logic        mispred_i,
  input  logic [31:0] mispred_tgt_i,
  input  logic        ret_i,
  input  logic [31:0] ra_i,
  input  logic        pred_i,
  input  logic [31:0] pred_tgt_i,
  input  logic        wfi_i,
  input  logic        intr_pend_i,
  output logic        pc_we_o,
  output logic [31:0] pc_next_o,
  output logic        flush_if_o,
  output logic        flush_id_o,
  output logic        trap_ack_o,
  output logic        sleeping_o
);

  localparam logic [3:0] TRAP_LOAD = 4'(TRAP_LAT - 1);

  fc_state_t   state, state_n;
  logic [3:0]  cnt, cnt_n;
  redir_src_t  pend_src, pend_src_n;
  logic [31:0] pend_tgt, pend_tgt_n;

  redir_src_t  win_src;
  logic [31:0] win_tgt;
  redir_src_t  sel_src;
  logic [31:0] sel_tgt;

  logic        we, fl_if, fl_id, ack;
  logic [31:0] nxt;

  redirect_prio_enc u_prio (
    .trap_req    (trap_req_i),
    .trap_vec    (trap_vec_i),
    .mret        (mret_i),
    .mepc        (mepc_i),
    .mispred     (mispred_i),
    .mispred_tgt (mispred_tgt_i),
    .ret         (ret_i),
    .ra          (ra_i),
    .pred        (pred_i),
    .pred_tgt    (pred_tgt_i),
    .wfi         (wfi_i),
    .cur_pc      (cur_pc_i),
    .src         (win_src),
    .tgt         (win_tgt)
  );

  // A pending redirect is only ever PRED or above, so ">=" also filters out SEQ/WFI.
  assign sel_src = (win_src >= pend_src) ? win_src : pend_src;
  assign sel_tgt = (win_src >= pend_src) ? win_tgt : pend_tgt;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    pend_src_n = pend_src;
    pend_tgt_n = pend_tgt;
    we         = 1'b0;
    nxt        = 32'd0;
    fl_if      = 1'b0;
    fl_id      = 1'b0;
    ack        = 1'b0;

    case (state)
      RUN: begin
        if (win_src == SRC_TRAP) begin
          fl_if   = 1'b1;
          fl_id   = 1'b1;
          cnt_n   = TRAP_LOAD;
          state_n = TRAP;
        end else if (win_src == SRC_WFI) begin
          state_n = WFI;
        end else if (stall_i) begin
          if (win_src != SRC_SEQ) begin
            pend_src_n = win_src;
            pend_tgt_n = win_tgt;
            state_n    = HOLD;
          end
        end else begin
          we    = 1'b1;
          nxt   = win_tgt;
          fl_if = kills_if(win_src);
          fl_id = kills_id(win_src);
        end
      end

      HOLD: begin
        if (win_src == SRC_TRAP) begin
          fl_if      = 1'b1;
          fl_id      = 1'b1;
          cnt_n      = TRAP_LOAD;
          pend_src_n = SRC_SEQ;
          pend_tgt_n = 32'd0;
          state_n    = TRAP;
        end else if (stall_i) begin
          pend_src_n = sel_src;
          pend_tgt_n = sel_tgt;
        end else begin
          we         = 1'b1;
          nxt        = sel_tgt;
          fl_if      = kills_if(sel_src);
          fl_id      = kills_id(sel_src);
          pend_src_n = SRC_SEQ;
          pend_tgt_n = 32'd0;
          state_n    = RUN;
        end
      end

      // The vector goes out in the cycle the counter runs out, so TRAP_LAT counts the entry cycle.
      TRAP: begin
        cnt_n = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        if ((cnt <= 4'd1) && !stall_i) begin
          we      = 1'b1;
          nxt     = align_pc(trap_vec_i);
          ack     = 1'b1;
          cnt_n   = 4'd0;
          state_n = RUN;
        end
      end

      WFI: begin
        if (trap_req_i) begin
          fl_if   = 1'b1;
          fl_id   = 1'b1;
          cnt_n   = TRAP_LOAD;
          state_n = TRAP;
        end else if (intr_pend_i) begin
          state_n = RUN;
        end
      end

      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= 4'd0;
      pend_src <= SRC_SEQ;
      pend_tgt <= 32'd0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pend_src <= pend_src_n;
      pend_tgt <= pend_tgt_n;
    end
  end

  // Outputs are combinational, so they are gated to keep them quiet throughout reset.
  assign pc_we_o    = we & ~rst;
  assign pc_next_o  = rst ? 32'd0 : nxt;
  assign flush_if_o = fl_if & ~rst;
  assign flush_id_o = fl_id & ~rst;
  assign trap_ack_o = ack & ~rst;
  assign sleeping_o = (state == WFI) & ~rst;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic [31:0] cur_pc_i;
  logic        trap_req_i;
  logic [31:0] trap_vec_i;
  logic        mret_i;
  logic [31:0] mepc_i;
  logic        mispred_i;
  logic [31:0] mispred_tgt_i;
  logic        ret_i;
  logic [31:0] ra_i;
  logic        pred_i;
  logic [31:0] pred_tgt_i;
  logic        wfi_i;
  logic        intr_pend_i;
  logic        pc_we_o;
  logic [31:0] pc_next_o;
  logic        flush_if_o;
  logic        flush_id_o;
  logic        trap_ack_o;
  logic        sleeping_o;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] nxt;
    logic        chk_nxt;
    logic        fif;
    logic        fid;
    logic        ack;
    logic        slp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.TRAP_LAT(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .cur_pc_i      (cur_pc_i),
    .trap_req_i    (trap_req_i),
    .trap_vec_i    (trap_vec_i),
    .mret_i        (mret_i),
    .mepc_i        (mepc_i),
    .mispred_i     (mispred_i),
    .mispred_tgt_i (mispred_tgt_i),
    .ret_i         (ret_i),
    .ra_i          (ra_i),
    .pred_i        (pred_i),
    .pred_tgt_i    (pred_tgt_i),
    .wfi_i         (wfi_i),
    .intr_pend_i   (intr_pend_i),
    .pc_we_o       (pc_we_o),
    .pc_next_o     (pc_next_o),
    .flush_if_o    (flush_if_o),
    .flush_id_o    (flush_id_o),
    .trap_ack_o    (trap_ack_o),
    .sleeping_o    (sleeping_o)
  );

  // Advance one cycle and return every request input to idle; cur_pc_i and rst persist.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    stall_i       = 1'b0;
    trap_req_i    = 1'b0;
    trap_vec_i    = 32'd0;
    mret_i        = 1'b0;
    mepc_i        = 32'd0;
    mispred_i     = 1'b0;
    mispred_tgt_i = 32'd0;
    ret_i         = 1'b0;
    ra_i          = 32'd0;
    pred_i        = 1'b0;
    pred_tgt_i    = 32'd0;
    wfi_i         = 1'b0;
    intr_pend_i   = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic we, input logic [31:0] nxt,
                             input logic fif, input logic fid, input logic ack, input logic slp);
    exp_t e;
    e.name    = name;
    e.we      = we;
    e.nxt     = nxt;
    e.chk_nxt = we | rst;
    e.fif     = fif;
    e.fid     = fid;
    e.ack     = ack;
    e.slp     = slp;
    exp_q.push_back(e);
  endtask

  task automatic compareField(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=0x%08h required=0x%08h", name, field, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      compareField(mon_e.name, "pc_we", {31'd0, pc_we_o}, {31'd0, mon_e.we});
      if (mon_e.chk_nxt)
        compareField(mon_e.name, "pc_next", pc_next_o, mon_e.nxt);
      compareField(mon_e.name, "flush_if", {31'd0, flush_if_o}, {31'd0, mon_e.fif});
      compareField(mon_e.name, "flush_id", {31'd0, flush_id_o}, {31'd0, mon_e.fid});
      compareField(mon_e.name, "trap_ack", {31'd0, trap_ack_o}, {31'd0, mon_e.ack});
      compareField(mon_e.name, "sleeping", {31'd0, sleeping_o}, {31'd0, mon_e.slp});
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst      = 1'b1;
    cur_pc_i = 32'h0000_2000;
    applyStimulus();
    checkOutput("reset", 0, 32'h0, 0, 0, 0, 0);

    applyStimulus();
    rst = 1'b0;
    checkOutput("seq", 1, 32'h2004, 0, 0, 0, 0);

    applyStimulus();
    pred_i = 1'b1; pred_tgt_i = 32'h100;
    mispred_i = 1'b1; mispred_tgt_i = 32'h200;
    checkOutput("mispred_over_pred", 1, 32'h200, 1, 1, 0, 0);

    applyStimulus();
    pred_i = 1'b1; pred_tgt_i = 32'h143;
    checkOutput("pred_align", 1, 32'h140, 1, 0, 0, 0);

    applyStimulus();
    mret_i = 1'b1; mepc_i = 32'h3000; ret_i = 1'b1; ra_i = 32'h4000;
    checkOutput("mret_over_ret", 1, 32'h3000, 1, 1, 0, 0);

    // Stall: pred then higher-priority ret replaces it.
    applyStimulus();
    stall_i = 1'b1; pred_i = 1'b1; pred_tgt_i = 32'h40;
    checkOutput("hold_c0", 0, 32'h0, 0, 0, 0, 0);
    applyStimulus();
    stall_i = 1'b1; ret_i = 1'b1; ra_i = 32'h80;
    checkOutput("hold_c1", 0, 32'h0, 0, 0, 0, 0);
    applyStimulus();
    stall_i = 1'b1;
    checkOutput("hold_c2", 0, 32'h0, 0, 0, 0, 0);
    applyStimulus();
    checkOutput("hold_release_ret", 1, 32'h80, 1, 0, 0, 0);

    // Lower priority dropped while holding.
    applyStimulus();
    stall_i = 1'b1; mispred_i = 1'b1; mispred_tgt_i = 32'h500;
    checkOutput("drop_c0", 0, 32'h0, 0, 0, 0, 0);
    applyStimulus();
    stall_i = 1'b1; pred_i = 1'b1; pred_tgt_i = 32'h600;
    checkOutput("drop_c1", 0, 32'h0, 0, 0, 0, 0);
    applyStimulus();
    checkOutput("drop_release", 1, 32'h500, 1, 1, 0, 0);

    // Equal priority: newest wins.
    applyStimulus();
    stall_i = 1'b1; pred_i = 1'b1; pred_tgt_i = 32'h10;
    checkOutput("tie_c0", 0, 32'h0, 0, 0, 0, 0);
    applyStimulus();
    stall_i = 1'b1; pred_i = 1'b1; pred_tgt_i = 32'h20;
    checkOutput("tie_c1", 0, 32'h0, 0, 0, 0, 0);
    applyStimulus();
    checkOutput("tie_release", 1, 32'h20, 1, 0, 0, 0);

    // Higher priority arriving in the release cycle.
    applyStimulus();
    stall_i = 1'b1; pred_i = 1'b1; pred_tgt_i = 32'h10;
    checkOutput("late_c0", 0, 32'h0, 0, 0, 0, 0);
    applyStimulus();
    mispred_i = 1'b1; mispred_tgt_i = 32'h700;
    checkOutput("late_release", 1, 32'h700, 1, 1, 0, 0);

    // Trap, TRAP_LAT=2, no stall.
    applyStimulus();
    trap_req_i = 1'b1; trap_vec_i = 32'h1000; mispred_i = 1'b1; mispred_tgt_i = 32'h900;
    checkOutput("trap_entry", 0, 32'h0, 1, 1, 0, 0);
    applyStimulus();
    trap_req_i = 1'b1; trap_vec_i = 32'h1000;
    checkOutput("trap_vector", 1, 32'h1000, 0, 0, 1, 0);
    applyStimulus();
    checkOutput("trap_after", 1, 32'h2004, 0, 0, 0, 0);

    // Trap with a stall in the vector cycle.
    applyStimulus();
    trap_req_i = 1'b1; trap_vec_i = 32'h1000;
    checkOutput("trapst_entry", 0, 32'h0, 1, 1, 0, 0);
    applyStimulus();
    trap_req_i = 1'b1; trap_vec_i = 32'h1000; stall_i = 1'b1;
    checkOutput("trapst_stalled", 0, 32'h0, 0, 0, 0, 0);
    applyStimulus();
    trap_req_i = 1'b1; trap_vec_i = 32'h1000;
    checkOutput("trapst_vector", 1, 32'h1000, 0, 0, 1, 0);

    // WFI sleep and interrupt wake.
    applyStimulus();
    wfi_i = 1'b1;
    checkOutput("wfi_enter", 0, 32'h0, 0, 0, 0, 0);
    applyStimulus();
    pred_i = 1'b1; pred_tgt_i = 32'h40;
    checkOutput("wfi_sleep", 0, 32'h0, 0, 0, 0, 1);
    applyStimulus();
    intr_pend_i = 1'b1;
    checkOutput("wfi_wake", 0, 32'h0, 0, 0, 0, 1);
    applyStimulus();
    checkOutput("wfi_resume", 1, 32'h2004, 0, 0, 0, 0);

    // WFI exit through trap.
    applyStimulus();
    wfi_i = 1'b1;
    checkOutput("wfitrap_enter", 0, 32'h0, 0, 0, 0, 0);
    applyStimulus();
    trap_req_i = 1'b1; trap_vec_i = 32'h1100;
    checkOutput("wfitrap_entry", 0, 32'h0, 1, 1, 0, 1);
    applyStimulus();
    trap_req_i = 1'b1; trap_vec_i = 32'h1100;
    checkOutput("wfitrap_vector", 1, 32'h1100, 0, 0, 1, 0);

    // Sequential wrap and ra alignment.
    applyStimulus();
    cur_pc_i = 32'hFFFF_FFFC;
    checkOutput("seq_wrap", 1, 32'h0, 0, 0, 0, 0);
    applyStimulus();
    ret_i = 1'b1; ra_i = 32'h103;
    checkOutput("ret_align", 1, 32'h100, 1, 0, 0, 0);
    cur_pc_i = 32'h0000_2000;

    // Reset while holding a pending redirect.
    applyStimulus();
    stall_i = 1'b1; pred_i = 1'b1; pred_tgt_i = 32'h40;
    checkOutput("rsthold_c0", 0, 32'h0, 0, 0, 0, 0);
    applyStimulus();
    stall_i = 1'b1; mispred_i = 1'b1; mispred_tgt_i = 32'h800;
    rst = 1'b1;
    checkOutput("rsthold_reset", 0, 32'h0, 0, 0, 0, 0);
    applyStimulus();
    rst = 1'b0;
    checkOutput("rsthold_after", 1, 32'h2004, 0, 0, 0, 0);

    applyStimulus();
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
